// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin arbiter that drives the
// 7:1 single-bit mux select.
package rr_mux_pkg;

  localparam int N_REQ = 7;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;

  // Ring successor: indices wrap at n, never at the 2^SEL_W boundary.
  function automatic int wrap_next(int idx, int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search: first requester at or after start,
// optionally skipping one index (used to find the next owner during a grant).
module rr_pick #(
  parameter int N     = rr_mux_pkg::N_REQ,
  parameter int SEL_W = rr_mux_pkg::SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] index
);

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path through the loop leaves a value held and no latch is inferred.
  always_comb begin : search
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = SEL_W'((int'(start) + off) % N);
      if (!found && req[cand] && !(excl_en && cand == excl_idx)) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner selection for the shared 7:1 mux: registered one-hot grant,
// mux select and owner index, with a hold limit that forces rotation.
module rr_mux_arbiter #(
  parameter int N        = rr_mux_pkg::N_REQ,
  parameter int SEL_W    = rr_mux_pkg::SEL_W,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] mux_select,
  output logic             valid,
  output logic [SEL_W-1:0] owner
);

  import rr_mux_pkg::*;

  localparam logic [SEL_W-1:0] HOLD_LAST = SEL_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]     ONE_HOT_0 = N'(1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] hold_cnt;
  logic             found;
  logic [SEL_W-1:0] cand;
  logic             take;
  logic             drop;

  // While granting, ptr always sits one past the owner, so the same search
  // start serves both the idle pick and the owner-excluded handover pick.
  rr_pick #(
    .N    (N),
    .SEL_W(SEL_W)
  ) u_pick (
    .req     (req),
    .start   (ptr),
    .excl_en (state == GRANT),
    .excl_idx(owner),
    .found   (found),
    .index   (cand)
  );

  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    if (state == IDLE) begin
      take = found;
    end else if (!req[owner] || hold_cnt == HOLD_LAST) begin
      take = found;
      drop = !found && !req[owner];
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      valid      <= 1'b0;
      mux_select <= SEL_IDLE;
      owner      <= '0;
      ptr        <= '0;
      hold_cnt   <= '0;
    end else if (take) begin
      state      <= GRANT;
      grant      <= ONE_HOT_0 << cand;
      valid      <= 1'b1;
      mux_select <= cand;
      owner      <= cand;
      ptr        <= SEL_W'(wrap_next(int'(cand), N));
      hold_cnt   <= '0;
    end else if (drop) begin
      // Back to idle outputs; ptr keeps the fairness position.
      state      <= IDLE;
      grant      <= '0;
      valid      <= 1'b0;
      mux_select <= SEL_IDLE;
      owner      <= '0;
      hold_cnt   <= '0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt   <= hold_cnt + 1'b1;
    end
  end

endmodule
